// File: rtl/bounce_gen_amisha.sv
// Contact-bounce emulator: turns a clean level-change request into an odd-length
// toggle burst on sw_out_amisha, then holds the final level for a settle window.
module bounce_gen_amisha #(
  parameter int GLITCH_W  = 8,
  parameter int SETTLE    = 1000000,
  parameter int DET_PAIRS = 2,
  parameter int DET_SEG   = 4
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       start_amisha,
  input  logic       level_amisha,
  input  logic       det_amisha,
  output logic       sw_out_amisha,
  output logic       busy_amisha,
  output logic       done_tick_amisha,
  output logic [3:0] bounce_cnt_amisha
);

  localparam int SET_W = $clog2(SETTLE);

  typedef enum logic [1:0] {ST_IDLE, ST_BOUNCE, ST_SETTLE} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
  logic [3:0]          remaining;
  logic [GLITCH_W-1:0] seg_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic                det_reg;
  logic                level_reg;

  // Galois form of x^16+x^14+x^13+x^11; a nonzero seed never reaches all-zero.
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state             <= ST_IDLE;
      lfsr              <= 16'hACE1;
      remaining         <= '0;
      seg_cnt           <= '0;
      settle_cnt        <= '0;
      det_reg           <= 1'b0;
      level_reg         <= 1'b0;
      sw_out_amisha     <= 1'b0;
      busy_amisha       <= 1'b0;
      done_tick_amisha  <= 1'b0;
      bounce_cnt_amisha <= '0;
    end else begin
      lfsr             <= lfsr_next;
      done_tick_amisha <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy_amisha <= 1'b0;
          if (start_amisha && (level_amisha != sw_out_amisha)) begin
            level_reg         <= level_amisha;
            det_reg           <= det_amisha;
            // 2P+1 toggles keeps the count odd so the burst ends on the requested level.
            remaining         <= det_amisha ? 4'(2 * DET_PAIRS + 1) : {lfsr[2:0], 1'b1};
            seg_cnt           <= '0;
            bounce_cnt_amisha <= '0;
            busy_amisha       <= 1'b1;
            state             <= ST_BOUNCE;
          end
        end

        ST_BOUNCE: begin
          if (seg_cnt == '0) begin
            bounce_cnt_amisha <= bounce_cnt_amisha + 4'd1;
            remaining         <= remaining - 4'd1;
            // Load L-1 so the next toggle lands exactly L cycles later.
            seg_cnt           <= det_reg ? GLITCH_W'(DET_SEG - 1) : lfsr[GLITCH_W-1:0];
            if (remaining == 4'd1) begin
              sw_out_amisha <= level_reg;
              settle_cnt    <= SET_W'(SETTLE - 1);
              state         <= ST_SETTLE;
            end else begin
              sw_out_amisha <= ~sw_out_amisha;
            end
          end else begin
            seg_cnt <= seg_cnt - 1'b1;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            done_tick_amisha <= 1'b1;
            state            <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen_amisha.sv
// Directed bench for bounce_gen_amisha: deterministic waveforms, ignored requests,
// mid-event reset, and property checks over LFSR-driven events.
module tb_bounce_gen_amisha;

  localparam int SETTLE_T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       level;
  logic       det;
  logic       sw;
  logic       busy;
  logic       done;
  logic [3:0] cnt;

  int checks = 0;
  int failures = 0;

  bounce_gen_amisha #(
    .GLITCH_W(8), .SETTLE(SETTLE_T), .DET_PAIRS(2), .DET_SEG(4)
  ) dut (
    .clk_amisha(clk),
    .reset_amisha(rst),
    .start_amisha(start),
    .level_amisha(level),
    .det_amisha(det),
    .sw_out_amisha(sw),
    .busy_amisha(busy),
    .done_tick_amisha(done),
    .bounce_cnt_amisha(cnt)
  );

  always #5 clk = ~clk;

  // Deterministic burst: toggles at c+1, c+5, c+9, c+13, c+17.
  function automatic int exp_toggles(int k);
    if (k < 1) return 0;
    if (k >= 17) return 5;
    return (k - 1) / 4 + 1;
  endfunction

  function automatic logic exp_sw(int k, logic fr);
    return (exp_toggles(k) % 2 == 1) ? ~fr : fr;
  endfunction

  // Presents start for exactly one rising edge (edge c); returns 1 time unit after it.
  task automatic pulse_start(input logic lvl, input logic d);
    @(negedge clk);
    start = 1'b1;
    level = lvl;
    det   = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; level = 1'b0; det = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sw, busy, done, cnt} !== 7'b0) begin
      failures++;
      $display("FAIL reset_state got=%b expected=0000000", {sw, busy, done, cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({sw, busy, done, cnt} !== 7'b0) begin
        failures++;
        $display("FAIL idle_after_reset k=%0d got=%b expected=0000000", k, {sw, busy, done, cnt});
      end
    end
  endtask

  task automatic test_det_event;
    pulse_start(1'b1, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      checks += 3;
      if (sw !== exp_sw(k, 1'b0)) begin
        failures++;
        $display("FAIL det_sw k=%0d got=%b expected=%b", k, sw, exp_sw(k, 1'b0));
      end
      if (done !== (k == 33)) begin
        failures++;
        $display("FAIL det_done k=%0d got=%b expected=%b", k, done, (k == 33));
      end
      if (busy !== (k <= 33)) begin
        failures++;
        $display("FAIL det_busy k=%0d got=%b expected=%b", k, busy, (k <= 33));
      end
    end
    checks++;
    if (cnt !== 4'd5) begin
      failures++;
      $display("FAIL det_cnt got=%0d expected=5", cnt);
    end
  endtask

  task automatic test_same_level;
    pulse_start(1'b1, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({sw, busy, done} !== 3'b100) begin
        failures++;
        $display("FAIL same_level k=%0d got=%b expected=100", k, {sw, busy, done});
      end
    end
    // Immediately request the opposite level.
    pulse_start(1'b0, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      checks += 2;
      if (sw !== exp_sw(k, 1'b1)) begin
        failures++;
        $display("FAIL fall_sw k=%0d got=%b expected=%b", k, sw, exp_sw(k, 1'b1));
      end
      if (done !== (k == 33)) begin
        failures++;
        $display("FAIL fall_done k=%0d got=%b expected=%b", k, done, (k == 33));
      end
    end
    checks++;
    if ({sw, cnt} !== 5'b0_0101) begin
      failures++;
      $display("FAIL fall_final got=%b expected=00101", {sw, cnt});
    end
  endtask

  task automatic test_start_while_busy;
    pulse_start(1'b1, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      checks += 2;
      if (sw !== exp_sw(k, 1'b0)) begin
        failures++;
        $display("FAIL busy_start_sw k=%0d got=%b expected=%b", k, sw, exp_sw(k, 1'b0));
      end
      if (done !== (k == 33)) begin
        failures++;
        $display("FAIL busy_start_done k=%0d got=%b expected=%b", k, done, (k == 33));
      end
      if (k == 6) begin
        start = 1'b1;
        level = 1'b0;
      end else if (k == 7) begin
        start = 1'b0;
      end
    end
    checks++;
    if ({sw, cnt} !== 5'b1_0101) begin
      failures++;
      $display("FAIL busy_start_final got=%b expected=10101", {sw, cnt});
    end
  endtask

  task automatic test_reset_mid_event;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if ({sw, busy, cnt} !== 6'b1_1_0011) begin
      failures++;
      $display("FAIL pre_reset got=%b expected=110011", {sw, busy, cnt});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sw, busy, done, cnt} !== 7'b0) begin
      failures++;
      $display("FAIL async_reset got=%b expected=0000000", {sw, busy, done, cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b1, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      checks += 2;
      if (sw !== exp_sw(k, 1'b0)) begin
        failures++;
        $display("FAIL fresh_sw k=%0d got=%b expected=%b", k, sw, exp_sw(k, 1'b0));
      end
      if (busy !== (k <= 33)) begin
        failures++;
        $display("FAIL fresh_busy k=%0d got=%b expected=%b", k, busy, (k <= 33));
      end
    end
  endtask

  task automatic test_random_events;
    logic lvl;
    logic prev;
    int   toggles;
    int   last_t;
    int   k;
    int   gap;
    bit   got_done;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int ev = 0; ev < 30; ev++) begin
      lvl = ~sw;
      prev = sw;
      pulse_start(lvl, 1'b0);
      toggles = 0; last_t = 0; k = 0; got_done = 1'b0;
      while (!got_done && k < 5000) begin
        k++;
        @(posedge clk);
        #1;
        if (sw !== prev) begin
          toggles++;
          gap = k - last_t;
          checks++;
          if (gap < 1 || gap > 256 || (toggles == 1 && gap != 1)) begin
            failures++;
            $display("FAIL rnd_gap ev=%0d toggle=%0d got=%0d expected=1..256", ev, toggles, gap);
          end
          last_t = k;
          prev = sw;
        end
        if (done === 1'b1) got_done = 1'b1;
      end
      checks += 5;
      if (!got_done) begin
        failures++;
        $display("FAIL rnd_timeout ev=%0d got=no_done expected=done_within_5000", ev);
      end
      if (cnt[0] !== 1'b1) begin
        failures++;
        $display("FAIL rnd_cnt_odd ev=%0d got=%0d expected=odd_1..15", ev, cnt);
      end
      if (toggles != int'(cnt)) begin
        failures++;
        $display("FAIL rnd_edges ev=%0d got=%0d expected=%0d", ev, toggles, cnt);
      end
      if (sw !== lvl) begin
        failures++;
        $display("FAIL rnd_final ev=%0d got=%b expected=%b", ev, sw, lvl);
      end
      if (k - last_t != SETTLE_T) begin
        failures++;
        $display("FAIL rnd_settle ev=%0d got=%0d expected=%0d", ev, k - last_t, SETTLE_T);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL rnd_after_done ev=%0d got=%b expected=00", ev, {busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_det_event();
    test_same_level();
    test_start_while_busy();
    test_reset_mid_event();
    test_random_events();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
